// File: rtl/pixel_burst_engine_if.sv
// Control and SRAM bus bundle for pixel_burst_engine.
// master = requester/SRAM side, slave = the engine.
interface pixel_burst_engine_if #(
  parameter int ADDR_W    = 16,
  parameter int PIX_W     = 8,
  parameter int BURST_MAX = 20,
  parameter int CNT_W     = 5
);
  logic                       start;
  logic [1:0]                 mode;
  logic [ADDR_W-1:0]          rd_base;
  logic [ADDR_W-1:0]          wr_base;
  logic [CNT_W-1:0]           rd_count;
  logic [CNT_W-1:0]           wr_count;
  logic [BURST_MAX*PIX_W-1:0] wr_pix;
  logic [BURST_MAX*PIX_W-1:0] rd_pix;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [ADDR_W-1:0]          address;
  logic [23:0]                w_data;
  logic [23:0]                r_data;
  logic                       read_enable;
  logic                       write_enable;

  modport master (
    output start, mode, rd_base, wr_base, rd_count, wr_count, wr_pix, r_data,
    input  rd_pix, busy, done, err, address, w_data, read_enable, write_enable
  );

  modport slave (
    input  start, mode, rd_base, wr_base, rd_count, wr_count, wr_pix, r_data,
    output rd_pix, busy, done, err, address, w_data, read_enable, write_enable
  );
endinterface

// File: rtl/pixel_burst_engine.sv
// Burst read/write engine between the edge-detection datapath and the RGB SRAM.
// state | meaning
// IDLE  | waiting for start; request latched and checked on accept
// RD    | reading pixels, each address held ACC_CYC cycles
// TURN  | one dead cycle between read and write phases
// WR    | writing replicated pixels, each held ACC_CYC cycles
// FIN   | one-cycle done pulse (err if request was rejected)
module pixel_burst_engine #(
  parameter int ADDR_W    = 16,
  parameter int PIX_W     = 8,
  parameter int BURST_MAX = 20,
  parameter int CNT_W     = 5,
  parameter int ACC_CYC   = 9,
  parameter int GRAY_EN   = 1
) (
  input logic clk,
  input logic n_rst,
  pixel_burst_engine_if.slave bus
);

  localparam int PIXV_W = BURST_MAX * PIX_W;
  localparam int TMR_W  = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);

  typedef enum logic [2:0] {IDLE, RD, TURN, WR, FIN} state_t;

  state_t state_q, state_d;

  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q, idx_q;
  logic [ADDR_W-1:0] wr_base_q, addr_q;
  logic [PIXV_W-1:0] buf_q, rd_pix_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              err_q;

  logic             use_rd, use_wr, bad, tc, last_rd, last_wr;
  logic             busy, done, err, read_enable, write_enable;
  logic [PIX_W-1:0] cap_pix, wr_sel;
  logic [7:0]       wr_pix8;

  always_comb begin
    use_rd = (bus.mode == 2'b00) || (bus.mode == 2'b10);
    use_wr = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    bad = (bus.mode == 2'b11)
       || (use_rd && (bus.rd_count == '0 || bus.rd_count > CNT_MAX))
       || (use_wr && (bus.wr_count == '0 || bus.wr_count > CNT_MAX));
  end

  assign tc      = (tmr_q == '0);
  assign last_rd = tc && (idx_q == rd_cnt_q - CNT_W'(1));
  assign last_wr = tc && (idx_q == wr_cnt_q - CNT_W'(1));

  // Greyscale approximates (R+G+B)/3 with shifts; the sum never exceeds 251.
  generate
    if (GRAY_EN != 0) begin : g_gray
      logic [9:0] sum;
      logic [7:0] grey;
      always_comb begin
        sum  = {2'b00, bus.r_data[23:16]} + {2'b00, bus.r_data[15:8]} + {2'b00, bus.r_data[7:0]};
        grey = 8'((sum >> 2) + (sum >> 4) + (sum >> 6) + (sum >> 8));
        cap_pix = grey[7 -: PIX_W];
      end
    end else begin : g_raw
      assign cap_pix = bus.r_data[PIX_W-1:0];
    end
  endgenerate

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < BURST_MAX; i++)
      if (idx_q == CNT_W'(i)) wr_sel = buf_q[i*PIX_W +: PIX_W];
    wr_pix8 = '0;
    wr_pix8[PIX_W-1:0] = wr_sel;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = bad ? FIN : ((bus.mode == 2'b01) ? WR : RD);
      RD: begin
        busy        = 1'b1;
        read_enable = 1'b1;
        if (last_rd) state_d = (mode_q == 2'b10) ? TURN : FIN;
      end
      TURN: begin
        busy    = 1'b1;
        state_d = WR;
      end
      WR: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        if (last_wr) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wr_base_q <= '0;
      addr_q    <= '0;
      buf_q     <= '0;
      rd_pix_q  <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          mode_q    <= bus.mode;
          rd_cnt_q  <= bus.rd_count;
          wr_cnt_q  <= bus.wr_count;
          wr_base_q <= bus.wr_base;
          buf_q     <= bus.wr_pix;
          err_q     <= bad;
          idx_q     <= '0;
          tmr_q     <= TMR_LOAD;
          if (!bad) addr_q <= (bus.mode == 2'b01) ? bus.wr_base : bus.rd_base;
        end
        RD: begin
          if (tc) begin
            for (int i = 0; i < BURST_MAX; i++)
              if (idx_q == CNT_W'(i)) rd_pix_q[i*PIX_W +: PIX_W] <= cap_pix;
            idx_q  <= idx_q + CNT_W'(1);
            tmr_q  <= TMR_LOAD;
            addr_q <= addr_q + ADDR_W'(1);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        TURN: begin
          idx_q  <= '0;
          tmr_q  <= TMR_LOAD;
          addr_q <= wr_base_q;
        end
        WR: begin
          if (tc) begin
            idx_q  <= idx_q + CNT_W'(1);
            tmr_q  <= TMR_LOAD;
            addr_q <= addr_q + ADDR_W'(1);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err;
  assign bus.read_enable  = read_enable;
  assign bus.write_enable = write_enable;
  assign bus.address      = addr_q;
  assign bus.rd_pix       = rd_pix_q;
  assign bus.w_data       = (state_q == WR) ? {3{wr_pix8}} : 24'h0;

endmodule
